axi4_lite_master_rw: RTL and testbench
======================================

# axi4_lite_master_rw

Single-outstanding AXI4-Lite master that turns a simple valid/ready command port into one AXI4-Lite read or write transaction. It returns the read data and response on a valid/ready response port. It is the initiator counterpart of the register-file slaves in the measurement cores. Control logic, for example an autonomous stats poller or a configuration sequencer, uses it to program and read those cores' register maps over the AXI4-Lite interconnect.

## Interface
- C_ADDR_WIDTH, 12, address width of the command and AR/AW channels
- C_AXI_WIDTH, 32, data width; only 32 and 64 are supported
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  C_ADDR_WIDTH  byte address
- cmd_wdata  in  C_AXI_WIDTH  write data
- cmd_wstrb  in  C_AXI_WIDTH/8  write byte strobes
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
- rsp_write  out  1  echo of cmd_write for this response
- rsp_resp  out  2  AXI response code (OKAY=00, SLVERR=10, DECERR=11)
- rsp_rdata  out  C_AXI_WIDTH  read data; 0 for writes and errors
- m_axi_awaddr/awprot/awvalid out, awready in; m_axi_wdata/wstrb/wvalid out, wready in; m_axi_bresp/bvalid in, bready out; m_axi_araddr/arprot/arvalid out, arready in; m_axi_rdata/rresp/rvalid in, rready out. These are standard AXI4-Lite channels with C_ADDR_WIDTH / C_AXI_WIDTH widths.

## Operation
- States: IDLE, WRITE, WRITE_RESP, READ_ADDR, READ_DATA, RESPOND.
- cmd_ready = (state == IDLE) & rst_n. Command fields are registered on acceptance; the command inputs are don't-care afterwards.
- Misaligned command: cmd_addr[log2(C_AXI_WIDTH/8)-1:0] != 0.
  - No bus transaction is issued.
  - The block goes directly to RESPOND with rsp_resp=10 and rsp_rdata=0.
- Aligned write: IDLE -> WRITE.
  - awvalid and wvalid are asserted together.
  - Each deasserts after its own handshake; the two handshakes may occur in either order or the same cycle.
  - When both are done, the block enters WRITE_RESP.
  - bready is high in WRITE and WRITE_RESP.
  - On bvalid & bready, bresp is captured and the block enters RESPOND.
  - A B handshake in WRITE is only legal after both AW and W are done. Once both are done, a B handshake in the same cycle goes straight to RESPOND.
- Aligned read: IDLE -> READ_ADDR (arvalid high until arready) -> READ_DATA (rready high).
  - On rvalid, rdata and rresp are captured and the block enters RESPOND.
  - rsp_rdata = rresp[1] ? 0 : rdata.
- RESPOND: rsp_valid is high and all response fields are stable until rsp_ready; the block then returns to IDLE.
- awaddr/araddr carry the registered command address; awprot = arprot = 000; wdata/wstrb carry the registered command values.
- While a VALID is high without its READY, all payload on that channel is held stable.
- At most one transaction is outstanding; there is no pipelining across commands.

## Timing
- Reset (rst_n low at an edge): state=IDLE; awvalid=wvalid=arvalid=bready=rready=0; rsp_valid=0; rsp_resp=00; rsp_rdata=0; rsp_write=0. cmd_ready is 0 while rst_n is low.
- Reset mid-transaction drops all VALIDs and READYs at that edge. The downstream slave must be reset by the same rst_n.
- All AXI and rsp outputs are registered; cmd_ready is decoded from the state only.
- Command accepted at cycle N -> awvalid/wvalid or arvalid high at N+1.
- Zero-wait slave: B/R valid at N+2, rsp_valid at N+3. Minimum latency is 3 cycles.
- Misaligned command: rsp_valid at N+1.
- rsp handshake at cycle M -> cmd_ready high at M+1. Back-to-back throughput is one command per 4 cycles minimum.
- Slave stalls add cycles one-for-one; there is no timeout.

## Test plan
- Write addr 0x004, data 0xDEADBEEF, wstrb 0xF, slave always ready, bresp 00 -> AW/W handshake at N+1, rsp_valid at N+3 with rsp_write=1, rsp_resp=00, rsp_rdata=0.
- Read addr 0x030, arready delayed 3 cycles, rvalid 2 cycles later with rdata 0x12345678 -> arvalid/araddr stable throughout the stall; rsp_rdata=0x12345678, rsp_resp=00.
- Write with awready at N+1 and wready at N+4 -> awvalid drops at N+2, wvalid stays high until N+4, bready stays high; a single rsp follows.
- Read returning rresp 10 with rdata 0xFFFFFFFF -> rsp_resp=10, rsp_rdata=0. Write returning bresp 11 -> rsp_resp=11.
- Command addr 0x006 (32-bit) -> no AR/AW/W activity, rsp_valid at N+1 with rsp_resp=10. Repeat with C_AXI_WIDTH=64 and addr 0x004 -> same result.
- Hold rsp_ready low for 5 cycles -> rsp fields stable and cmd_ready low; then assert rsp_ready -> cmd_ready high next cycle. Separately, assert rst_n low while awvalid is high -> all valids 0 next cycle and state returns to IDLE.

Source files
------------

// File: rtl/axi4_lite_master_rw.sv
// axi4_lite_master_rw: single-outstanding AXI4-Lite master.
// Turns one valid/ready command into one read or write transaction.
module axi4_lite_master_rw #(
    parameter int C_ADDR_WIDTH = 12,
    // Only 32 and 64 are supported.
    parameter int C_AXI_WIDTH  = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [C_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [C_AXI_WIDTH-1:0]    cmd_wdata,
    input  logic [C_AXI_WIDTH/8-1:0]  cmd_wstrb,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic                      rsp_write,
    output logic [1:0]                rsp_resp,
    output logic [C_AXI_WIDTH-1:0]    rsp_rdata,
    output logic [C_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [2:0]                m_axi_awprot,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    output logic [C_AXI_WIDTH-1:0]    m_axi_wdata,
    output logic [C_AXI_WIDTH/8-1:0]  m_axi_wstrb,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,
    output logic [C_ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [2:0]                m_axi_arprot,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    input  logic [C_AXI_WIDTH-1:0]    m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready
);

    localparam int LSB = $clog2(C_AXI_WIDTH / 8);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        WRITE_RESP,
        READ_ADDR,
        READ_DATA,
        RESPOND
    } state_t;

    state_t                     state;
    logic [C_ADDR_WIDTH-1:0]    addr_q;
    logic [C_AXI_WIDTH-1:0]     wdata_q;
    logic [C_AXI_WIDTH/8-1:0]   wstrb_q;
    logic                       misaligned;
    logic                       aw_fin;
    logic                       w_fin;

    // A valid that is already low in WRITE means its handshake is done.
    assign misaligned = (cmd_addr[LSB-1:0] != '0);
    assign aw_fin     = !m_axi_awvalid || m_axi_awready;
    assign w_fin      = !m_axi_wvalid || m_axi_wready;

    assign cmd_ready    = (state == IDLE) && rst_n;
    assign m_axi_awaddr = addr_q;
    assign m_axi_araddr = addr_q;
    assign m_axi_awprot = 3'b000;
    assign m_axi_arprot = 3'b000;
    assign m_axi_wdata  = wdata_q;
    assign m_axi_wstrb  = wstrb_q;

    // Transaction FSM with registered AXI and response outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_write     <= 1'b0;
            rsp_resp      <= 2'b00;
            rsp_rdata     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        addr_q  <= cmd_addr;
                        wdata_q <= cmd_wdata;
                        wstrb_q <= cmd_wstrb;
                        if (misaligned) begin
                            rsp_valid <= 1'b1;
                            rsp_write <= cmd_write;
                            rsp_resp  <= 2'b10;
                            rsp_rdata <= '0;
                            state     <= RESPOND;
                        end else if (cmd_write) begin
                            m_axi_awvalid <= 1'b1;
                            m_axi_wvalid  <= 1'b1;
                            m_axi_bready  <= 1'b1;
                            state         <= WRITE;
                        end else begin
                            m_axi_arvalid <= 1'b1;
                            state         <= READ_ADDR;
                        end
                    end
                end
                WRITE: begin
                    if (m_axi_awready) m_axi_awvalid <= 1'b0;
                    if (m_axi_wready)  m_axi_wvalid  <= 1'b0;
                    if (aw_fin && w_fin) begin
                        if (m_axi_bvalid) begin
                            m_axi_bready <= 1'b0;
                            rsp_valid    <= 1'b1;
                            rsp_write    <= 1'b1;
                            rsp_resp     <= m_axi_bresp;
                            rsp_rdata    <= '0;
                            state        <= RESPOND;
                        end else begin
                            state <= WRITE_RESP;
                        end
                    end
                end
                WRITE_RESP: begin
                    if (m_axi_bvalid) begin
                        m_axi_bready <= 1'b0;
                        rsp_valid    <= 1'b1;
                        rsp_write    <= 1'b1;
                        rsp_resp     <= m_axi_bresp;
                        rsp_rdata    <= '0;
                        state        <= RESPOND;
                    end
                end
                READ_ADDR: begin
                    if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b1;
                        state         <= READ_DATA;
                    end
                end
                READ_DATA: begin
                    if (m_axi_rvalid) begin
                        m_axi_rready <= 1'b0;
                        rsp_valid    <= 1'b1;
                        rsp_write    <= 1'b0;
                        rsp_resp     <= m_axi_rresp;
                        rsp_rdata    <= m_axi_rresp[1] ? '0 : m_axi_rdata;
                        state        <= RESPOND;
                    end
                end
                RESPOND: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_lite_master_rw.sv
// tb_axi4_lite_master_rw: directed bench for axi4_lite_master_rw.
// Drives and samples on the falling edge; DUT acts on the rising edge.
module tb_axi4_lite_master_rw;

    logic        clk = 1'b0;
    logic        rst_n;

    // 32-bit instance
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [11:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_write;
    logic [1:0]  rsp_resp;
    logic [31:0] rsp_rdata;
    logic [11:0] awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        bvalid, bready, arvalid, arready, rvalid, rready;

    // 64-bit instance
    logic        d_cmd_valid, d_cmd_ready, d_cmd_write;
    logic [11:0] d_cmd_addr;
    logic [63:0] d_cmd_wdata;
    logic [7:0]  d_cmd_wstrb;
    logic        d_rsp_valid, d_rsp_ready, d_rsp_write;
    logic [1:0]  d_rsp_resp;
    logic [63:0] d_rsp_rdata;
    logic [11:0] d_awaddr, d_araddr;
    logic [2:0]  d_awprot, d_arprot;
    logic        d_awvalid, d_awready, d_wvalid, d_wready;
    logic [63:0] d_wdata, d_rdata;
    logic [7:0]  d_wstrb;
    logic [1:0]  d_bresp, d_rresp;
    logic        d_bvalid, d_bready, d_arvalid, d_arready;
    logic        d_rvalid, d_rready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axi4_lite_master_rw #(.C_ADDR_WIDTH(12), .C_AXI_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_write(rsp_write), .rsp_resp(rsp_resp),
        .rsp_rdata(rsp_rdata),
        .m_axi_awaddr(awaddr), .m_axi_awprot(awprot),
        .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
        .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid),
        .m_axi_bready(bready),
        .m_axi_araddr(araddr), .m_axi_arprot(arprot),
        .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp),
        .m_axi_rvalid(rvalid), .m_axi_rready(rready)
    );

    axi4_lite_master_rw #(.C_ADDR_WIDTH(12), .C_AXI_WIDTH(64)) dut64 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(d_cmd_valid), .cmd_ready(d_cmd_ready),
        .cmd_write(d_cmd_write), .cmd_addr(d_cmd_addr),
        .cmd_wdata(d_cmd_wdata), .cmd_wstrb(d_cmd_wstrb),
        .rsp_valid(d_rsp_valid), .rsp_ready(d_rsp_ready),
        .rsp_write(d_rsp_write), .rsp_resp(d_rsp_resp),
        .rsp_rdata(d_rsp_rdata),
        .m_axi_awaddr(d_awaddr), .m_axi_awprot(d_awprot),
        .m_axi_awvalid(d_awvalid), .m_axi_awready(d_awready),
        .m_axi_wdata(d_wdata), .m_axi_wstrb(d_wstrb),
        .m_axi_wvalid(d_wvalid), .m_axi_wready(d_wready),
        .m_axi_bresp(d_bresp), .m_axi_bvalid(d_bvalid),
        .m_axi_bready(d_bready),
        .m_axi_araddr(d_araddr), .m_axi_arprot(d_arprot),
        .m_axi_arvalid(d_arvalid), .m_axi_arready(d_arready),
        .m_axi_rdata(d_rdata), .m_axi_rresp(d_rresp),
        .m_axi_rvalid(d_rvalid), .m_axi_rready(d_rready)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic send(input logic wr, input logic [11:0] a,
                        input logic [31:0] d);
        check("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_wstrb = 4'hF;
        step();
        cmd_valid = 1'b0;
        cmd_addr  = 12'hFFF;
        cmd_wdata = 32'h0;
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("rsp_done", rsp_valid, 0);
        check("cmd_ready_back", cmd_ready, 1);
    endtask

    initial begin
        rst_n = 1'b0;
        cmd_valid = 0; cmd_write = 0; cmd_addr = 0;
        cmd_wdata = 0; cmd_wstrb = 0; rsp_ready = 0;
        awready = 0; wready = 0; bresp = 0; bvalid = 0;
        arready = 0; rdata = 0; rresp = 0; rvalid = 0;
        d_cmd_valid = 0; d_cmd_write = 0; d_cmd_addr = 0;
        d_cmd_wdata = 0; d_cmd_wstrb = 0; d_rsp_ready = 0;
        d_awready = 0; d_wready = 0; d_bresp = 0; d_bvalid = 0;
        d_arready = 0; d_rdata = 0; d_rresp = 0; d_rvalid = 0;
        step();
        step();
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_valids", {awvalid, wvalid, arvalid}, 0);
        check("rst_readies", {bready, rready}, 0);
        check("rst_rsp", {rsp_valid, rsp_write, rsp_resp}, 0);
        check("rst_rdata", rsp_rdata, 0);
        rst_n = 1'b1;
        step();

        // Zero-wait write
        awready = 1; wready = 1;
        send(1'b1, 12'h004, 32'hDEADBEEF);
        check("w1_aw_w_valid", {awvalid, wvalid}, 2'b11);
        check("w1_awaddr", awaddr, 12'h004);
        check("w1_wdata", wdata, 32'hDEADBEEF);
        check("w1_wstrb", wstrb, 4'hF);
        check("w1_prot", {awprot, arprot}, 0);
        check("w1_bready", bready, 1);
        step();
        check("w1_aw_w_drop", {awvalid, wvalid}, 0);
        check("w1_bready2", bready, 1);
        check("w1_no_rsp", rsp_valid, 0);
        bvalid = 1; bresp = 2'b00;
        step();
        bvalid = 0;
        check("w1_rsp_valid", rsp_valid, 1);
        check("w1_rsp_write", rsp_write, 1);
        check("w1_rsp_resp", rsp_resp, 2'b00);
        check("w1_rsp_rdata", rsp_rdata, 0);
        check("w1_bready_off", bready, 0);
        take_rsp();
        awready = 0; wready = 0;

        // Read with arready stalled 3 cycles
        send(1'b0, 12'h030, 32'h0);
        for (int i = 0; i < 3; i++) begin
            check("r1_arvalid_hold", arvalid, 1);
            check("r1_araddr_hold", araddr, 12'h030);
            check("r1_no_write", {awvalid, wvalid}, 0);
            step();
        end
        check("r1_arvalid", arvalid, 1);
        arready = 1;
        step();
        arready = 0;
        check("r1_ar_drop", arvalid, 0);
        check("r1_rready", rready, 1);
        step();
        check("r1_rready2", rready, 1);
        rvalid = 1; rdata = 32'h12345678; rresp = 2'b00;
        step();
        rvalid = 0; rdata = 0;
        for (int i = 0; i < 5; i++) begin
            check("r1_rsp_valid", rsp_valid, 1);
            check("r1_rsp_rdata", rsp_rdata, 32'h12345678);
            check("r1_rsp_resp", {rsp_write, rsp_resp}, 3'b000);
            check("r1_cmd_ready_lo", cmd_ready, 0);
            step();
        end
        take_rsp();

        // Write: AW at N+1, W at N+4, bresp DECERR
        send(1'b1, 12'h010, 32'hA5A5_0F0F);
        check("w2_valids_n1", {awvalid, wvalid}, 2'b11);
        awready = 1;
        step();
        awready = 0;
        check("w2_aw_drop", awvalid, 0);
        check("w2_w_hold", wvalid, 1);
        check("w2_bready", bready, 1);
        step();
        check("w2_w_hold3", {awvalid, wvalid, bready}, 3'b011);
        check("w2_wdata_hold", wdata, 32'hA5A5_0F0F);
        step();
        check("w2_w_hold4", {awvalid, wvalid, bready}, 3'b011);
        wready = 1;
        step();
        wready = 0;
        check("w2_w_drop", {awvalid, wvalid, bready}, 3'b001);
        check("w2_no_rsp", rsp_valid, 0);
        bvalid = 1; bresp = 2'b11;
        step();
        bvalid = 0; bresp = 0;
        check("w2_rsp_valid", rsp_valid, 1);
        check("w2_rsp_resp", rsp_resp, 2'b11);
        check("w2_rsp_write", rsp_write, 1);
        take_rsp();
        step();
        check("w2_single_rsp", rsp_valid, 0);

        // Read with SLVERR
        send(1'b0, 12'h040, 32'h0);
        arready = 1;
        step();
        arready = 0;
        rvalid = 1; rdata = 32'hFFFFFFFF; rresp = 2'b10;
        step();
        rvalid = 0; rdata = 0; rresp = 0;
        check("r2_rsp_valid", rsp_valid, 1);
        check("r2_rsp_resp", rsp_resp, 2'b10);
        check("r2_rsp_rdata", rsp_rdata, 0);
        take_rsp();

        // Misaligned on 32-bit
        send(1'b0, 12'h006, 32'h0);
        check("m1_rsp_valid", rsp_valid, 1);
        check("m1_rsp_resp", rsp_resp, 2'b10);
        check("m1_rsp_rdata", rsp_rdata, 0);
        check("m1_no_bus", {awvalid, wvalid, arvalid}, 0);
        take_rsp();

        // Misaligned write on 64-bit (addr 0x004)
        check("m2_cmd_ready", d_cmd_ready, 1);
        d_cmd_valid = 1; d_cmd_write = 1; d_cmd_addr = 12'h004;
        d_cmd_wdata = 64'h1; d_cmd_wstrb = 8'hFF;
        step();
        d_cmd_valid = 0;
        check("m2_rsp_valid", d_rsp_valid, 1);
        check("m2_rsp_resp", d_rsp_resp, 2'b10);
        check("m2_rsp_write", d_rsp_write, 1);
        check("m2_no_bus", {d_awvalid, d_wvalid, d_arvalid}, 0);
        d_rsp_ready = 1;
        step();
        d_rsp_ready = 0;
        check("m2_cmd_ready_back", d_cmd_ready, 1);

        // Aligned 64-bit read at 0x008
        d_cmd_valid = 1; d_cmd_write = 0; d_cmd_addr = 12'h008;
        d_arready = 1;
        step();
        d_cmd_valid = 0;
        check("a64_arvalid", d_arvalid, 1);
        check("a64_araddr", d_araddr, 12'h008);
        step();
        d_arready = 0;
        d_rvalid = 1; d_rdata = 64'h0123_4567_89AB_CDEF;
        step();
        d_rvalid = 0;
        check("a64_rsp_valid", d_rsp_valid, 1);
        check("a64_rsp_rdata", d_rsp_rdata, 64'h0123_4567_89AB_CDEF);
        d_rsp_ready = 1;
        step();
        d_rsp_ready = 0;

        // Reset while awvalid is high
        send(1'b1, 12'h020, 32'h5555_AAAA);
        check("rs_awvalid", {awvalid, wvalid}, 2'b11);
        rst_n = 0;
        step();
        check("rs_valids", {awvalid, wvalid, arvalid}, 0);
        check("rs_readies", {bready, rready, rsp_valid}, 0);
        check("rs_cmd_ready_lo", cmd_ready, 0);
        rst_n = 1;
        #1;
        check("rs_idle", cmd_ready, 1);
        step();
        check("rs_idle2", cmd_ready, 1);
        check("rs_quiet", {awvalid, wvalid}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
